// File: rtl/reg_xfer_ctrl.sv
// Register-transfer sequencer for a 4 x 8-bit register group: read operands, run an ALU op, write back.
// Define REG_XFER_SHIFT_EN to make opcodes 1010 (SHL) and 1011 (SHR) legal writing operations.
module reg_xfer_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] instr,
  input  logic [7:0] imm,
  input  logic [7:0] s,
  input  logic [7:0] d,
  output logic [1:0] sr,
  output logic [1:0] dr,
  output logic       we,
  output logic [7:0] i,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       cf,
  output logic       zf
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0] r_state;
  logic [3:0] r_op;
  logic [7:0] r_imm;
  logic [1:0] r_sr;
  logic [1:0] r_dr;
  logic       r_we;
  logic [7:0] r_i;
  logic       r_busy;
  logic       r_done;
  logic       r_err;
  logic       r_cf;
  logic       r_zf;

  logic [7:0] w_res;
  logic       w_cf;
  logic       w_legal;
  logic       w_write;

  assign sr   = r_sr;
  assign dr   = r_dr;
  assign we   = r_we;
  assign i    = r_i;
  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;
  assign cf   = r_cf;
  assign zf   = r_zf;

  // ALU: a is the destination read (d), b the source read (s)
  always_comb begin
    w_res   = 8'h00;
    w_cf    = 1'b0;
    w_legal = 1'b1;
    w_write = 1'b1;
    case (r_op)
      4'h0: w_write = 1'b0;
      4'h1: w_res = r_imm;
      4'h2: w_res = s;
      4'h3: {w_cf, w_res} = {1'b0, d} + {1'b0, s};
      4'h4: begin
        w_res = d - s;
        w_cf  = (d < s);
      end
      4'h5: w_res = d & s;
      4'h6: w_res = d | s;
      4'h7: w_res = d ^ s;
      4'h8: w_res = ~s;
      4'h9: {w_cf, w_res} = {1'b0, d} + 9'd1;
`ifdef REG_XFER_SHIFT_EN
      4'hA: begin
        w_res = {d[6:0], 1'b0};
        w_cf  = d[7];
      end
      4'hB: begin
        w_res = {1'b0, d[7:1]};
        w_cf  = d[0];
      end
`endif
      default: begin
        w_legal = 1'b0;
        w_write = 1'b0;
      end
    endcase
  end

  // Sequencer; selects are held in IDLE so the register group keeps seeing the last operands
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op    <= 4'h0;
      r_imm   <= 8'h00;
      r_sr    <= 2'd0;
      r_dr    <= 2'd0;
      r_we    <= 1'b0;
      r_i     <= 8'h00;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_cf    <= 1'b0;
      r_zf    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op    <= instr[7:4];
            r_imm   <= imm;
            r_sr    <= instr[1:0];
            r_dr    <= instr[3:2];
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_READ;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_READ: r_state <= ST_EXEC;
        ST_EXEC: begin
          if (!w_legal) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else if (!w_write) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_i     <= w_res;
            r_cf    <= w_cf;
            r_zf    <= (w_res == 8'h00);
            r_we    <= 1'b1;
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          r_we    <= 1'b0;
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_we    <= 1'b0;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Self-checking bench for reg_xfer_ctrl: register-group model, ISA-level reference model, per-cycle compare.
module tb_reg_xfer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] instr;
  logic [7:0] imm;
  logic [7:0] s;
  logic [7:0] d;
  logic [1:0] sr;
  logic [1:0] dr;
  logic       we;
  logic [7:0] i;
  logic       busy;
  logic       done;
  logic       err;
  logic       cf;
  logic       zf;

  int nvec = 0;
  int nerr = 0;
  int wecnt = 0;
  bit chk_en = 1'b0;

  reg_xfer_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .instr(instr), .imm(imm),
    .s(s), .d(d), .sr(sr), .dr(dr), .we(we), .i(i),
    .busy(busy), .done(done), .err(err), .cf(cf), .zf(zf)
  );

  always #5 clk = ~clk;

  // Register group environment: combinational reads, capture on falling edge when we=1
  logic [7:0] grp [4] = '{default: 8'h00};
  assign s = grp[sr];
  assign d = grp[dr];
  always @(negedge clk) begin
    if (we) begin
      grp[dr] <= i;
      wecnt   <= wecnt + 1;
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ISA semantics of one opcode
  task automatic isa(input logic [3:0] op, input int a, input int b, input int im,
                     output bit legal, output bit wr, output logic [7:0] res, output bit c);
    int r;
    legal = 1'b1; wr = 1'b1; r = 0; c = 1'b0;
    case (op)
      4'h0: wr = 1'b0;
      4'h1: r = im;
      4'h2: r = b;
      4'h3: begin r = a + b; c = (r > 255); end
      4'h4: begin r = a - b; c = (a < b); end
      4'h5: r = a & b;
      4'h6: r = a | b;
      4'h7: r = a ^ b;
      4'h8: r = 255 - b;
      4'h9: begin r = a + 1; c = (a == 255); end
`ifdef REG_XFER_SHIFT_EN
      4'hA: begin r = a * 2; c = (a >= 128); end
      4'hB: begin r = a / 2; c = (a % 2 == 1); end
`endif
      default: begin legal = 1'b0; wr = 1'b0; end
    endcase
    res = r[7:0];
  endtask

  // Reference model: architectural registers and the cycle count since an accepted start
  logic [7:0] ref_r [4] = '{default: 8'h00};
  int         phase = 0;
  int         m_last = 3;
  bit         m_write = 1'b0;
  logic [7:0] m_ins = 8'h00;
  logic [7:0] m_imm = 8'h00;
  logic [7:0] m_res = 8'h00;
  bit         m_err = 1'b0;
  bit         m_cf = 1'b0;
  bit         m_zf = 1'b0;

  always @(posedge clk) begin
    bit lg, wr, c;
    logic [7:0] r;
    if (rst) begin
      phase = 0; m_err = 1'b0; m_cf = 1'b0; m_zf = 1'b0; m_write = 1'b0;
    end else if (phase == 0) begin
      if (start) begin
        m_ins = instr; m_imm = imm; m_err = 1'b0;
        isa(instr[7:4], 0, 0, 0, lg, wr, r, c);
        m_write = wr;
        m_last  = wr ? 4 : 3;
        phase   = 1;
      end
    end else if (phase == m_last) begin
      phase = 0;
    end else begin
      phase = phase + 1;
      if (phase == 3) begin
        isa(m_ins[7:4], ref_r[m_ins[3:2]], ref_r[m_ins[1:0]], m_imm, lg, wr, r, c);
        if (!lg) m_err = 1'b1;
        else if (wr) begin
          ref_r[m_ins[3:2]] = r;
          m_res = r; m_cf = c; m_zf = (r == 8'h00);
        end
      end
    end
  end

  // Per-cycle compare of DUT outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {7'd0, busy}, {7'd0, phase != 0});
      chk("done", {7'd0, done}, {7'd0, phase != 0 && phase == m_last});
      chk("we", {7'd0, we}, {7'd0, m_write && phase == 3});
      chk("cf", {7'd0, cf}, {7'd0, m_cf});
      chk("zf", {7'd0, zf}, {7'd0, m_zf});
      chk("err", {7'd0, err}, {7'd0, m_err});
      if (phase != 0) begin
        chk("sr", {6'd0, sr}, {6'd0, m_ins[1:0]});
        chk("dr", {6'd0, dr}, {6'd0, m_ins[3:2]});
      end
      if (m_write && phase == 3) chk("wdata", i, m_res);
    end
  end

  task automatic run(input logic [7:0] ins, input logic [7:0] im, output int lat);
    @(negedge clk);
    start = 1'b1; instr = ins; imm = im;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 20) begin
      nerr++;
      $display("FAIL timeout: done not seen for instr %h", ins);
    end
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int w0;
    rst = 1'b1; start = 1'b0; instr = 8'h00; imm = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", {7'd0, busy}, 8'h00);
    chk("rst_i", i, 8'h00);
    chk("rst_srdr", {4'd0, sr, dr}, 8'h00);
    chk("rst_flags", {4'd0, we, err, cf, zf}, 8'h00);
    chk_en = 1'b1;

    // LDI R2,5A
    run(8'h18, 8'h5A, lat);
    chk("ldi_lat", lat[7:0], 8'd4);
    chk("ldi_r2", grp[2], 8'h5A);
    chk("ldi_model", ref_r[2], 8'h5A);
    chk("ldi_flags", {6'd0, cf, zf}, 8'h00);
    chk("ldi_wecnt", wecnt[7:0], 8'd1);

    // ADD R0,R1 then SUB R1,R1
    run(8'h10, 8'hF0, lat);
    run(8'h14, 8'h20, lat);
    run(8'h31, 8'h00, lat);
    chk("add_r0", grp[0], 8'h10);
    chk("add_flags", {6'd0, cf, zf}, 8'h02);
    run(8'h45, 8'h00, lat);
    chk("sub_r1", grp[1], 8'h00);
    chk("sub_flags", {6'd0, cf, zf}, 8'h01);

    // Illegal opcode: no write, flags unchanged
    w0 = wecnt;
    run(8'hF0, 8'h00, lat);
    chk("ill_lat", lat[7:0], 8'd3);
    chk("ill_err", {7'd0, err}, 8'h01);
    chk("ill_nowe", 8'(wecnt - w0), 8'd0);
    chk("ill_flags", {6'd0, cf, zf}, 8'h01);

    // start held high through a whole instruction (LDI R2,33)
    w0 = wecnt;
    @(negedge clk);
    start = 1'b1; instr = 8'h18; imm = 8'h33;
    repeat (5) @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("held_wecnt", 8'(wecnt - w0), 8'd1);
    chk("held_r2", grp[2], 8'h33);
    chk("held_err", {7'd0, err}, 8'h00);

    // Second start pulse during EXEC with a different instruction is ignored
    w0 = wecnt;
    @(negedge clk);
    start = 1'b1; instr = 8'h18; imm = 8'h44;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; instr = 8'h10; imm = 8'h77;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pulse_wecnt", 8'(wecnt - w0), 8'd1);
    chk("pulse_r2", grp[2], 8'h44);
    chk("pulse_r0", grp[0], 8'h10);

    // Reset during EXEC of LDI R3,AA
    w0 = wecnt;
    @(negedge clk);
    start = 1'b1; instr = 8'h1C; imm = 8'hAA;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_out", {busy, done, we, err, cf, zf, 2'b00}, 8'h00);
    chk("abort_srdr", {4'd0, sr, dr}, 8'h00);
    chk("abort_i", i, 8'h00);
    repeat (2) @(negedge clk);
    chk("abort_nowe", 8'(wecnt - w0), 8'd0);
    chk("abort_r3", grp[3], 8'h00);

    // SHL R1 on 81
    run(8'h14, 8'h81, lat);
    run(8'hA5, 8'h00, lat);
`ifdef REG_XFER_SHIFT_EN
    chk("shl_r1", grp[1], 8'h02);
    chk("shl_cf", {7'd0, cf}, 8'h01);
    chk("shl_err", {7'd0, err}, 8'h00);
`else
    chk("shl_r1", grp[1], 8'h81);
    chk("shl_err", {7'd0, err}, 8'h01);
    chk("shl_flags", {6'd0, cf, zf}, 8'h00);
`endif

    for (int k = 0; k < 4; k++) chk("final_reg", grp[k], ref_r[k]);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
